// File: rtl/prog_fetch_unit.sv
// Instruction fetch stage: issues program-memory reads, assembles one- and two-word
// AVR instructions, and presents them to the decoder with a valid/stall handshake.
module prog_fetch_unit #(
    parameter logic [13:0] RESET_VEC = 14'h0000,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rst,
    output logic [13:0] PC,
    output logic        PC_RD,
    input  logic        RDY,
    input  logic [15:0] Dout,
    input  logic        branch_valid,
    input  logic [13:0] branch_target,
    input  logic        stall,
    output logic        instr_valid,
    output logic [15:0] instr,
    output logic [15:0] instr_k,
    output logic [13:0] instr_pc,
    output logic        instr_is32,
    output logic        fetch_err
);

    typedef enum logic [2:0] {RST_IDLE, REQ1, WAIT1, REQ2, WAIT2, HOLD} state_t;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [13:0]       fetch_pc_q, fetch_pc_d;
    logic              flush_q, flush_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [15:0]       instr_q, instr_d;
    logic [15:0]       instr_k_q, instr_k_d;
    logic [13:0]       instr_pc_q, instr_pc_d;
    logic              is32_q, is32_d;
    logic [13:0]       pc_q, pc_d;
    logic              pc_rd_q, pc_rd_d;
    logic              valid_q, valid_d;

    // JMP/CALL and LDS/STS carry a second operand word.
    function automatic logic is_two_word(input logic [15:0] w);
        return ((w & 16'hFE0C) == 16'h940C) || ((w & 16'hFC0F) == 16'h9000);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RST_IDLE;
            fetch_pc_q <= RESET_VEC;
            flush_q    <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            instr_q    <= '0;
            instr_k_q  <= '0;
            instr_pc_q <= '0;
            is32_q     <= 1'b0;
            pc_q       <= RESET_VEC;
            pc_rd_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            flush_q    <= flush_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            instr_q    <= instr_d;
            instr_k_q  <= instr_k_d;
            instr_pc_q <= instr_pc_d;
            is32_q     <= is32_d;
            pc_q       <= pc_d;
            pc_rd_q    <= pc_rd_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        flush_d    = flush_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        instr_d    = instr_q;
        instr_k_d  = instr_k_q;
        instr_pc_d = instr_pc_q;
        is32_d     = is32_q;
        case (state_q)
            RST_IDLE: begin
                state_d = REQ1;
                if (branch_valid) fetch_pc_d = branch_target;
            end
            REQ1, REQ2: begin
                state_d = (state_q == REQ1) ? WAIT1 : WAIT2;
                cnt_d   = '0;
                // The read is already issued; it must still be drained in WAIT.
                if (branch_valid) begin
                    flush_d    = 1'b1;
                    fetch_pc_d = branch_target;
                end
            end
            WAIT1, WAIT2: begin
                if (branch_valid) fetch_pc_d = branch_target;
                if (RDY) begin
                    if (flush_q || branch_valid) begin
                        flush_d = 1'b0;
                        state_d = REQ1;
                    end else if (state_q == WAIT1) begin
                        instr_d    = Dout;
                        instr_pc_d = fetch_pc_q;
                        instr_k_d  = '0;
                        is32_d     = 1'b0;
                        state_d    = is_two_word(Dout) ? REQ2 : HOLD;
                    end else begin
                        instr_k_d = Dout;
                        is32_d    = 1'b1;
                        state_d   = HOLD;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    err_d = 1'b1;
                    if (flush_q || branch_valid) begin
                        flush_d = 1'b0;
                        state_d = REQ1;
                    end else begin
                        state_d = (state_q == WAIT1) ? REQ1 : REQ2;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (branch_valid) flush_d = 1'b1;
                end
            end
            HOLD: begin
                if (branch_valid) begin
                    fetch_pc_d = branch_target;
                    state_d    = REQ1;
                end else if (!stall) begin
                    fetch_pc_d = instr_pc_q + 14'd1 + {13'd0, is32_q};
                    state_d    = REQ1;
                end
            end
            default: state_d = RST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered.
    always_comb begin
        pc_d = pc_q;
        case (state_d)
            REQ1:    pc_d = fetch_pc_d;
            REQ2:    pc_d = fetch_pc_d + 14'd1;
            default: pc_d = pc_q;
        endcase
        pc_rd_d = (state_d == REQ1) || (state_d == REQ2);
        valid_d = (state_d == HOLD);
    end

    assign PC          = pc_q;
    assign PC_RD       = pc_rd_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_k     = instr_k_q;
    assign instr_pc    = instr_pc_q;
    assign instr_is32  = is32_q;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_prog_fetch_unit.sv
// Directed bench for prog_fetch_unit with a one-cycle-latency program memory model.
module tb_prog_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] PC;
    logic        PC_RD;
    logic        RDY = 1'b0;
    logic [15:0] Dout = 16'h0000;
    logic        branch_valid = 1'b0;
    logic [13:0] branch_target = 14'h0000;
    logic        stall = 1'b1;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_k;
    logic [13:0] instr_pc;
    logic        instr_is32;
    logic        fetch_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rd_overlap = 0;
    bit prev_rd = 0;
    bit auto_rdy = 1;
    bit pend = 0;
    logic [13:0] pend_addr = 14'h0000;
    logic [15:0] mem [0:16383];

    prog_fetch_unit dut (
        .clk(clk), .rst(rst), .PC(PC), .PC_RD(PC_RD), .RDY(RDY), .Dout(Dout),
        .branch_valid(branch_valid), .branch_target(branch_target), .stall(stall),
        .instr_valid(instr_valid), .instr(instr), .instr_k(instr_k),
        .instr_pc(instr_pc), .instr_is32(instr_is32), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    // One clock; memory answers a PC_RD seen this cycle with RDY in the next one.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (prev_rd && PC_RD) rd_overlap++;
        prev_rd = PC_RD;
        if (auto_rdy) begin
            RDY  = pend;
            Dout = pend ? mem[pend_addr] : 16'h0000;
        end
        pend      = PC_RD;
        pend_addr = PC;
    endtask

    task automatic wait_rd(output bit ok);
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            if (PC_RD === 1'b1) ok = 1;
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL wait_rd: no PC_RD seen, required within 200 cycles"); end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            if (instr_valid === 1'b1) ok = 1;
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL wait_valid: no instr_valid seen, required within 200 cycles"); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (PC !== 14'h0000) begin failures++; $display("FAIL reset_pc: got %h want 0000", PC); end
        checks++; if (PC_RD !== 1'b0) begin failures++; $display("FAIL reset_pc_rd: got %b want 0", PC_RD); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        checks++; if ({instr, instr_k} !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h want 0", {instr, instr_k}); end
        checks++; if ({instr_pc, instr_is32, fetch_err} !== 16'h0) begin failures++; $display("FAIL reset_misc: got %h want 0", {instr_pc, instr_is32, fetch_err}); end
        rst = 1'b0;
    endtask

    task automatic test_one_word();
        bit ok;
        int n;
        wait_rd(ok);
        n = cyc;
        checks++; if (PC !== 14'h0000) begin failures++; $display("FAIL first_pc: got %h want 0000", PC); end
        wait_valid(ok);
        checks++; if (cyc - n !== 2) begin failures++; $display("FAIL one_word_latency: got %0d want 2", cyc - n); end
        checks++; if (instr !== 16'h0C01) begin failures++; $display("FAIL one_word_instr: got %h want 0c01", instr); end
        checks++; if (instr_is32 !== 1'b0 || instr_k !== 16'h0) begin failures++; $display("FAIL one_word_is32: got %b/%h want 0/0000", instr_is32, instr_k); end
        checks++; if (instr_pc !== 14'h0000) begin failures++; $display("FAIL one_word_pc: got %h want 0000", instr_pc); end
        stall = 1'b0;
        tick();
        stall = 1'b1;
        checks++; if (PC_RD !== 1'b1 || PC !== 14'h0001) begin failures++; $display("FAIL next_fetch: got rd=%b pc=%h want rd=1 pc=0001", PC_RD, PC); end
        wait_valid(ok);
    endtask

    task automatic test_stall();
        bit ok;
        int bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (instr_valid !== 1'b1 || PC_RD !== 1'b0 || instr !== 16'h0000 || instr_pc !== 14'h0001) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad); end
        stall = 1'b0;
        tick();
        stall = 1'b1;
        checks++; if (PC_RD !== 1'b1 || PC !== 14'h0002) begin failures++; $display("FAIL stall_release: got rd=%b pc=%h want rd=1 pc=0002", PC_RD, PC); end
        wait_valid(ok);
    endtask

    task automatic test_two_word(input logic [13:0] a, input logic [15:0] w1, input logic [15:0] w2,
                                 input logic [13:0] a2, input logic [13:0] anext);
        bit ok;
        int n;
        branch_valid = 1'b1; branch_target = a;
        tick();
        branch_valid = 1'b0;
        n = cyc;
        checks++; if (PC_RD !== 1'b1 || PC !== a) begin failures++; $display("FAIL two_word_req1: got rd=%b pc=%h want rd=1 pc=%h", PC_RD, PC, a); end
        wait_rd(ok);
        checks++; if (PC !== a2 || cyc - n !== 2) begin failures++; $display("FAIL two_word_req2: got pc=%h dt=%0d want pc=%h dt=2", PC, cyc - n, a2); end
        wait_valid(ok);
        checks++; if (cyc - n !== 4) begin failures++; $display("FAIL two_word_latency: got %0d want 4", cyc - n); end
        checks++; if (instr !== w1 || instr_k !== w2) begin failures++; $display("FAIL two_word_data: got %h/%h want %h/%h", instr, instr_k, w1, w2); end
        checks++; if (instr_is32 !== 1'b1 || instr_pc !== a) begin failures++; $display("FAIL two_word_meta: got is32=%b pc=%h want 1/%h", instr_is32, instr_pc, a); end
        stall = 1'b0;
        tick();
        stall = 1'b1;
        checks++; if (PC_RD !== 1'b1 || PC !== anext) begin failures++; $display("FAIL two_word_next: got rd=%b pc=%h want rd=1 pc=%h", PC_RD, PC, anext); end
        wait_valid(ok);
    endtask

    task automatic test_branch();
        bit ok;
        auto_rdy = 0; RDY = 1'b0;
        stall = 1'b0;
        tick();
        stall = 1'b1;
        tick();
        branch_valid = 1'b1; branch_target = 14'h0040;
        tick();
        branch_valid = 1'b0;
        RDY = 1'b1; Dout = 16'h940C;
        tick();
        RDY = 1'b0;
        checks++; if (PC_RD !== 1'b1 || PC !== 14'h0040 || instr_valid !== 1'b0) begin failures++; $display("FAIL branch_wait: got rd=%b pc=%h v=%b want 1/0040/0", PC_RD, PC, instr_valid); end
        tick();
        RDY = 1'b1; Dout = 16'h1111; branch_valid = 1'b1;
        tick();
        RDY = 1'b0; branch_valid = 1'b0;
        checks++; if (PC_RD !== 1'b1 || PC !== 14'h0040 || instr_valid !== 1'b0) begin failures++; $display("FAIL branch_rdy: got rd=%b pc=%h v=%b want 1/0040/0", PC_RD, PC, instr_valid); end
        auto_rdy = 1;
        wait_valid(ok);
        checks++; if (instr !== 16'h2222 || instr_pc !== 14'h0040) begin failures++; $display("FAIL branch_target_instr: got %h@%h want 2222@0040", instr, instr_pc); end
    endtask

    task automatic test_timeout_and_reset();
        bit ok;
        int bad = 0;
        auto_rdy = 0; RDY = 1'b0;
        stall = 1'b0;
        tick();
        stall = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (PC_RD !== 1'b0 || fetch_err !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL timeout_early: got %0d bad cycles want 0", bad); end
        tick();
        checks++; if (PC_RD !== 1'b1 || PC !== 14'h0041 || fetch_err !== 1'b1) begin failures++; $display("FAIL timeout_retry: got rd=%b pc=%h err=%b want 1/0041/1", PC_RD, PC, fetch_err); end
        auto_rdy = 1;
        wait_rd(ok);
        checks++; if (PC !== 14'h0042) begin failures++; $display("FAIL timeout_req2: got %h want 0042", PC); end
        auto_rdy = 0; RDY = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (fetch_err !== 1'b0 || instr_valid !== 1'b0 || PC !== 14'h0000) begin failures++; $display("FAIL midreset_state: got err=%b v=%b pc=%h want 0/0/0000", fetch_err, instr_valid, PC); end
        RDY = 1'b1; Dout = 16'h940C;
        tick();
        RDY = 1'b0;
        checks++; if (PC_RD !== 1'b1 || PC !== 14'h0000 || instr_valid !== 1'b0) begin failures++; $display("FAIL midreset_restart: got rd=%b pc=%h v=%b want 1/0000/0", PC_RD, PC, instr_valid); end
        auto_rdy = 1;
        wait_valid(ok);
        checks++; if (instr !== 16'h0C01 || instr_pc !== 14'h0000 || instr_is32 !== 1'b0) begin failures++; $display("FAIL midreset_instr: got %h@%h is32=%b want 0c01@0000 0", instr, instr_pc, instr_is32); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int c1, c2, c3;
        logic [13:0] p1, p2, p3;
        stall = 1'b0;
        wait_rd(ok); c1 = cyc; p1 = PC;
        wait_rd(ok); c2 = cyc; p2 = PC;
        wait_rd(ok); c3 = cyc; p3 = PC;
        stall = 1'b1;
        checks++; if (c2 - c1 !== 3 || c3 - c2 !== 3) begin failures++; $display("FAIL b2b_spacing: got %0d,%0d want 3,3", c2 - c1, c3 - c2); end
        checks++; if ({p1, p2, p3} !== {14'h0001, 14'h0002, 14'h0003}) begin failures++; $display("FAIL b2b_addr: got %h %h %h want 0001 0002 0003", p1, p2, p3); end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 16'h0000;
        mem[0]      = 16'h0C01;
        mem[5]      = 16'h940C;
        mem[6]      = 16'h1234;
        mem[14'h3FFF] = 16'h9100;
        mem[14'h0040] = 16'h2222;
        mem[14'h0041] = 16'h940C;
        mem[14'h0042] = 16'h5555;

        test_reset();
        test_one_word();
        test_stall();
        test_two_word(14'h0005, 16'h940C, 16'h1234, 14'h0006, 14'h0007);
        test_two_word(14'h3FFF, 16'h9100, 16'h0C01, 14'h0000, 14'h0001);
        test_branch();
        test_timeout_and_reset();
        test_back_to_back();
        checks++; if (rd_overlap !== 0) begin failures++; $display("FAIL pc_rd_overlap: got %0d want 0", rd_overlap); end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
